// File: rtl/valu_issue_ctrl.sv
// Issue/scoreboard/retire controller for the vector ALU: in-order two-stage
// tracking, RAW interlock, Vcompsel serialization and writeback backpressure.
module valu_issue_ctrl #(
  parameter int unsigned TAGW = 5,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [7:0]      in_imm,
  input  logic [TAGW-1:0] in_dst,
  input  logic [TAGW-1:0] in_vsrc1,
  input  logic [TAGW-1:0] in_vsrc2,
  input  logic [TAGW-1:0] in_ssrc1,
  input  logic [TAGW-1:0] in_ssrc2,
  input  logic [3:0]      in_use,
  output logic            alu_en,
  output logic [4:0]      alu_op,
  output logic [7:0]      alu_imm,
  output logic            op_hold,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [TAGW-1:0] wb_dst,
  output logic            wb_vec,
  output logic            err,
  output logic [CNTW-1:0] issued_cnt,
  output logic [CNTW-1:0] err_cnt
);

  typedef enum logic [4:0] {
    OP_FADD     = 5'd0,
    OP_FSUB     = 5'd1,
    OP_FMULT    = 5'd2,
    OP_VADD     = 5'd3,
    OP_VSUB     = 5'd4,
    OP_VMULT    = 5'd5,
    OP_VDOT     = 5'd6,
    OP_VDOTA    = 5'd7,
    OP_VINDX    = 5'd8,
    OP_VREDUCE  = 5'd9,
    OP_VSPLAT   = 5'd10,
    OP_VSWIZZLE = 5'd11,
    OP_VSADD    = 5'd12,
    OP_VSSUB    = 5'd13,
    OP_VSMULT   = 5'd14,
    OP_VSMA     = 5'd15,
    OP_VCOMPSEL = 5'd16,
    OP_VMAX     = 5'd17,
    OP_VMIN     = 5'd18
  } op_e;

  typedef struct packed {
    logic            valid;
    logic [4:0]      op;
    logic [7:0]      imm;
    logic [TAGW-1:0] dst;
    logic            vec;
  } entry_t;

  entry_t          r_s1;
  entry_t          r_s2;
  logic            r_err;
  logic [CNTW-1:0] r_issued_cnt;
  logic [CNTW-1:0] r_err_cnt;

  logic   w_alu_en;
  logic   w_legal;
  logic   w_serial;
  logic   w_pipe_empty;
  logic   w_cs_inflight;
  logic   w_hazard;
  logic   w_ready;
  logic   w_accept;
  logic   w_issue;
  entry_t w_new;

  function automatic logic f_scalar_dst(input logic [4:0] op);
    logic res;
    res = 1'b0;
    case (op)
      OP_FADD, OP_FSUB, OP_FMULT, OP_VDOT, OP_VDOTA, OP_VINDX, OP_VREDUCE: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic f_hit(input entry_t e, input logic [TAGW-1:0] src,
                                 input logic vec);
    return e.valid && (e.vec == vec) && (e.dst == src);
  endfunction

  // Sources compare only against in-flight entries writing the same file;
  // the retiring S2 entry still blocks because there is no bypass.
  always_comb begin
    w_hazard = 1'b0;
    if (in_use[0] && (f_hit(r_s1, in_vsrc1, 1'b1) || f_hit(r_s2, in_vsrc1, 1'b1)))
      w_hazard = 1'b1;
    if (in_use[1] && (f_hit(r_s1, in_vsrc2, 1'b1) || f_hit(r_s2, in_vsrc2, 1'b1)))
      w_hazard = 1'b1;
    if (in_use[2] && (f_hit(r_s1, in_ssrc1, 1'b0) || f_hit(r_s2, in_ssrc1, 1'b0)))
      w_hazard = 1'b1;
    if (in_use[3] && (f_hit(r_s1, in_ssrc2, 1'b0) || f_hit(r_s2, in_ssrc2, 1'b0)))
      w_hazard = 1'b1;
  end

  always_comb begin
    w_alu_en      = !(r_s2.valid && !wb_ready);
    w_legal       = (in_op < 5'd19) && (in_op != OP_VSMA);
    w_serial      = (in_op == OP_VCOMPSEL);
    w_pipe_empty  = !r_s1.valid && !r_s2.valid;
    w_cs_inflight = (r_s1.valid && (r_s1.op == OP_VCOMPSEL)) ||
                    (r_s2.valid && (r_s2.op == OP_VCOMPSEL));
    w_ready       = !rst && w_alu_en && !w_hazard && !(w_serial && !w_pipe_empty) &&
                    !w_cs_inflight;
    w_accept      = in_valid && w_ready;
    w_issue       = w_accept && w_legal;
  end

  always_comb begin
    w_new.valid = w_issue;
    w_new.op    = in_op;
    w_new.imm   = in_imm;
    w_new.dst   = in_dst;
    w_new.vec   = !f_scalar_dst(in_op);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else if (w_alu_en) begin
      r_s2 <= r_s1;
      // Payload fields only update on a real issue; a bubble just clears valid.
      if (w_issue) r_s1 <= w_new;
      else         r_s1.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err        <= 1'b0;
      r_issued_cnt <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_issue && (r_issued_cnt != '1))
        r_issued_cnt <= r_issued_cnt + CNTW'(1);
      if (w_accept && !w_legal && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + CNTW'(1);
    end
  end

  assign in_ready   = w_ready;
  assign alu_en     = w_alu_en;
  assign alu_op     = w_issue ? in_op : 5'd0;
  assign alu_imm    = r_s2.imm;
  assign op_hold    = w_cs_inflight;
  assign wb_valid   = r_s2.valid;
  assign wb_dst     = r_s2.dst;
  assign wb_vec     = r_s2.vec;
  assign err        = r_err;
  assign issued_cnt = r_issued_cnt;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_valu_issue_ctrl.sv
// Directed bench for valu_issue_ctrl: stream, RAW, backpressure, Vcompsel,
// illegal ops and mid-flight reset, with hand-derived expectations.
module tb_valu_issue_ctrl;
  localparam int unsigned TAGW = 5;
  localparam int unsigned CNTW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [7:0]      in_imm;
  logic [TAGW-1:0] in_dst;
  logic [TAGW-1:0] in_vsrc1;
  logic [TAGW-1:0] in_vsrc2;
  logic [TAGW-1:0] in_ssrc1;
  logic [TAGW-1:0] in_ssrc2;
  logic [3:0]      in_use;
  logic            alu_en;
  logic [4:0]      alu_op;
  logic [7:0]      alu_imm;
  logic            op_hold;
  logic            wb_valid;
  logic            wb_ready;
  logic [TAGW-1:0] wb_dst;
  logic            wb_vec;
  logic            err;
  logic [CNTW-1:0] issued_cnt;
  logic [CNTW-1:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

  valu_issue_ctrl #(.TAGW(TAGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_dst(in_dst),
    .in_vsrc1(in_vsrc1), .in_vsrc2(in_vsrc2), .in_ssrc1(in_ssrc1), .in_ssrc2(in_ssrc2),
    .in_use(in_use), .alu_en(alu_en), .alu_op(alu_op), .alu_imm(alu_imm),
    .op_hold(op_hold), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst),
    .wb_vec(wb_vec), .err(err), .issued_cnt(issued_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [7:0] imm,
                       input logic [TAGW-1:0] dst, input logic [3:0] use_f,
                       input logic [TAGW-1:0] vs1, input logic [TAGW-1:0] ss1);
    in_valid = v;
    in_op    = op;
    in_imm   = imm;
    in_dst   = dst;
    in_use   = use_f;
    in_vsrc1 = vs1;
    in_ssrc1 = ss1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb_ready = 1'b1;
    in_vsrc2 = '0; in_ssrc2 = '0;
    drive(1'b0, 5'd0, 8'h00, 5'd0, 4'b0000, 5'd0, 5'd0);
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_alu_en", alu_en, 1);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_imm", alu_imm, 0);
    chk("rst_op_hold", op_hold, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_dst", wb_dst, 0);
    chk("rst_wb_vec", wb_vec, 0);
    chk("rst_err", err, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_errcnt", err_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);

    // Independent stream: Vadd d1, Vsub d2, Fadd d3
    drive(1'b1, 5'd3, 8'h00, 5'd1, 4'b0000, 5'd0, 5'd0); #1;
    chk("s_rdy0", in_ready, 1);
    chk("s_aluop0", alu_op, 3);
    tick();
    drive(1'b1, 5'd4, 8'h00, 5'd2, 4'b0000, 5'd0, 5'd0); #1;
    chk("s_rdy1", in_ready, 1);
    chk("s_wbv_early", wb_valid, 0);
    tick();
    drive(1'b1, 5'd0, 8'h00, 5'd3, 4'b0000, 5'd0, 5'd0); #1;
    chk("s_rdy2", in_ready, 1);
    chk("s_wbv1", wb_valid, 1);
    chk("s_dst1", wb_dst, 1);
    chk("s_vec1", wb_vec, 1);
    tick();
    drive(1'b0, 5'd0, 8'h00, 5'd0, 4'b0000, 5'd0, 5'd0); #1;
    chk("s_wbv2", wb_valid, 1);
    chk("s_dst2", wb_dst, 2);
    chk("s_vec2", wb_vec, 1);
    tick();
    chk("s_wbv3", wb_valid, 1);
    chk("s_dst3", wb_dst, 3);
    chk("s_vec3", wb_vec, 0);
    tick();
    chk("s_wbv_end", wb_valid, 0);
    chk("s_issued", issued_cnt, 3);

    // RAW: Vmult v4 then Vadd vsrc1=v4
    drive(1'b1, 5'd5, 8'h00, 5'd4, 4'b0000, 5'd0, 5'd0); #1;
    chk("raw_rdy_prod", in_ready, 1);
    tick();
    drive(1'b1, 5'd3, 8'h00, 5'd5, 4'b0001, 5'd4, 5'd0); #1;
    chk("raw_blk1", in_ready, 0);
    chk("raw_aluop_blk", alu_op, 0);
    tick();
    chk("raw_blk2", in_ready, 0);
    chk("raw_prod_wb", wb_dst, 4);
    tick();
    chk("raw_free", in_ready, 1);
    chk("raw_wbv_gone", wb_valid, 0);
    tick();
    drive(1'b0, 5'd0, 8'h00, 5'd0, 4'b0000, 5'd0, 5'd0); #1;
    tick();
    chk("raw_cons_wbv", wb_valid, 1);
    chk("raw_cons_dst", wb_dst, 5);
    tick();
    chk("raw_drain", wb_valid, 0);

    // Backpressure on Vswizzle imm 0x1B
    drive(1'b1, 5'd11, 8'h1B, 5'd7, 4'b0000, 5'd0, 5'd0); #1;
    chk("bp_rdy", in_ready, 1);
    tick();
    drive(1'b0, 5'd0, 8'h00, 5'd0, 4'b0000, 5'd0, 5'd0); #1;
    tick();
    wb_ready = 1'b0;
    drive(1'b1, 5'd3, 8'h00, 5'd9, 4'b0000, 5'd0, 5'd0); #1;
    for (int i = 0; i < 5; i++) begin
      if (i != 0) tick();
      chk("bp_alu_en", alu_en, 0);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_alu_imm", alu_imm, 8'h1B);
      chk("bp_wb_dst", wb_dst, 7);
      chk("bp_wb_valid", wb_valid, 1);
    end
    wb_ready = 1'b1; #1;
    chk("bp_resume_rdy", in_ready, 1);
    chk("bp_resume_en", alu_en, 1);
    tick();
    drive(1'b0, 5'd0, 8'h00, 5'd0, 4'b0000, 5'd0, 5'd0); #1;
    chk("bp_no_dup", wb_valid, 0);
    tick();
    chk("bp_next_wbv", wb_valid, 1);
    chk("bp_next_dst", wb_dst, 9);
    tick();
    chk("bp_drain", wb_valid, 0);
    chk("bp_issued", issued_cnt, 7);

    // Vcompsel behind Fmult
    drive(1'b1, 5'd2, 8'h00, 5'd10, 4'b0000, 5'd0, 5'd0); #1;
    tick();
    drive(1'b1, 5'd16, 8'h00, 5'd11, 4'b0000, 5'd0, 5'd0); #1;
    chk("cs_blk1", in_ready, 0);
    tick();
    chk("cs_blk2", in_ready, 0);
    chk("cs_fmult_vec", wb_vec, 0);
    tick();
    chk("cs_free", in_ready, 1);
    chk("cs_aluop", alu_op, 16);
    tick();
    drive(1'b1, 5'd3, 8'h00, 5'd12, 4'b0000, 5'd0, 5'd0); #1;
    chk("cs_hold1", op_hold, 1);
    chk("cs_next_blk1", in_ready, 0);
    tick();
    chk("cs_hold2", op_hold, 1);
    chk("cs_next_blk2", in_ready, 0);
    chk("cs_wb_dst", wb_dst, 11);
    tick();
    chk("cs_hold_off", op_hold, 0);
    chk("cs_next_rdy", in_ready, 1);
    tick();
    drive(1'b0, 5'd0, 8'h00, 5'd0, 4'b0000, 5'd0, 5'd0); #1;
    tick();
    chk("cs_next_wb", wb_dst, 12);
    chk("cs_issued", issued_cnt, 10);
    tick();

    // Illegal ops 15 and 20
    drive(1'b1, 5'd15, 8'h00, 5'd1, 4'b0000, 5'd0, 5'd0); #1;
    chk("il_rdy1", in_ready, 1);
    chk("il_aluop", alu_op, 0);
    tick();
    drive(1'b1, 5'd20, 8'h00, 5'd2, 4'b0000, 5'd0, 5'd0); #1;
    chk("il_err1", err, 1);
    chk("il_cnt1", err_cnt, 1);
    chk("il_rdy2", in_ready, 1);
    tick();
    drive(1'b0, 5'd0, 8'h00, 5'd0, 4'b0000, 5'd0, 5'd0); #1;
    chk("il_err2", err, 1);
    chk("il_cnt2", err_cnt, 2);
    chk("il_wbv_a", wb_valid, 0);
    tick();
    chk("il_err_off", err, 0);
    chk("il_wbv_b", wb_valid, 0);
    tick();
    chk("il_wbv_c", wb_valid, 0);
    chk("il_issued", issued_cnt, 10);

    // Reset with two entries in flight
    drive(1'b1, 5'd3, 8'h00, 5'd13, 4'b0000, 5'd0, 5'd0); #1;
    tick();
    drive(1'b1, 5'd4, 8'h00, 5'd14, 4'b0000, 5'd0, 5'd0); #1;
    tick();
    chk("mr_wbv_pre", wb_valid, 1);
    rst = 1'b1;
    drive(1'b0, 5'd0, 8'h00, 5'd0, 4'b0000, 5'd0, 5'd0); #1;
    chk("mr_rdy_in_rst", in_ready, 0);
    tick();
    rst = 1'b0; #1;
    chk("mr_wbv0", wb_valid, 0);
    chk("mr_rdy", in_ready, 1);
    chk("mr_issued", issued_cnt, 0);
    tick();
    chk("mr_wbv1", wb_valid, 0);
    tick();
    chk("mr_wbv2", wb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/valu_issue_ctrl.md
# valu_issue_ctrl

Issue, scoreboard and retire controller for the vector ALU. It sits between the decoder and the register-file write port, and drives the ALU's `op`, `imm` and `en` signals. It accepts one instruction per cycle over a valid/ready handshake and tracks the two in-flight pipeline stages. It blocks RAW hazards, since the ALU has no bypass. It presents each result's destination and kind on a valid/ready writeback port, and stalls the whole ALU whenever writeback backpressures.

## Interface
Parameters:
- `TAGW`, default 5: register index width, shared by the scalar and vector files.
- `CNTW`, default 16: width of the statistics counters.

Ports:
- `clk`, in, 1: clock; one clock domain.
- `rst`, in, 1: reset; synchronous, active-high.
- `in_valid`, in, 1: decoder has an instruction.
- `in_ready`, out, 1: instruction accepted this cycle when `in_valid && in_ready`.
- `in_op`, in, 5: ALU opcode, 0..18.
- `in_imm`, in, 8: immediate for Vindx/Vswizzle.
- `in_dst`, in, TAGW: destination register index.
- `in_vsrc1`, `in_vsrc2`, `in_ssrc1`, `in_ssrc2`, in, TAGW each: source register indices.
- `in_use`, in, 4: source-used flags {ssrc2, ssrc1, vsrc2, vsrc1}.
- `alu_en`, out, 1: ALU pipeline advance enable.
- `alu_op`, out, 5: opcode presented to ALU stage 0.
- `alu_imm`, out, 8: immediate of the stage-2 entry.
- `op_hold`, out, 1: operand-read stage must keep presenting r1/r2 unchanged.
- `wb_valid`, out, 1: stage-2 entry is valid and its result is on the ALU outputs.
- `wb_ready`, in, 1: register file accepts the writeback.
- `wb_dst`, out, TAGW: destination of the retiring entry.
- `wb_vec`, out, 1: 1 selects vector file (vout), 0 selects scalar file (rout).
- `err`, out, 1: one-cycle pulse when an illegal op is dropped.
- `issued_cnt`, `err_cnt`, out, CNTW each: saturating counters.

## Operation
- Opcodes: Fadd 0, Fsub 1, Fmult 2, Vadd 3, Vsub 4, Vmult 5, Vdot 6, Vdota 7, Vindx 8, Vreduce 9, Vsplat 10, Vswizzle 11, Vsadd 12, Vssub 13, Vsmult 14, Vsma 15, Vcompsel 16, Vmax 17, Vmin 18.
- Scalar-destination ops (`wb_vec`=0): 0, 1, 2, 6, 7, 8, 9. All other legal ops write the vector file (`wb_vec`=1).
- Illegal ops are `in_op` ≥ 19, and Vsma (15, not supported by the ALU).
  - They are accepted (`in_ready` obeys the normal rules) and dropped: no pipeline entry is created.
  - `err` pulses the next cycle and `err_cnt` increments.
- Pipeline state: entry registers S1 and S2, each holding {valid, op, imm, dst, vec}.
- When `alu_en`=1: S2 takes S1, and S1 takes the new issue or a bubble (valid=0).
- `alu_op` = `in_op` on an issue cycle, otherwise 0 (bubble). Bubble results are never written back.
- `alu_en` = !(S2.valid && !wb_ready).
- `wb_valid` = S2.valid. `wb_dst`/`wb_vec` come from S2. `alu_imm` = S2.imm (the ALU consumes imm unpipelined at its output stage).
- Hazard: a used source is a hazard if it matches the dst of a valid entry in S1 or S2 in the same file. Vector sources compare against vec=1 entries; scalar sources compare against vec=0 entries.
  - The retiring entry counts as a hazard; there is no same-cycle bypass.
- Serializing op: Vcompsel (16), because it reads r1/r2 live at the output stage.
  - It issues only when S1 and S2 are both empty.
  - While it is in flight, `op_hold`=1 and no other issue occurs.
- `in_ready` = !rst && `alu_en` && !hazard && !(serializing op && pipe not empty) && no Vcompsel in flight.
- Counters saturate at all-ones. `issued_cnt` counts legal issues only.

## Timing
- Reset (`rst`=1 at a clock edge): S1/S2 valid cleared; counters 0.
  - Outputs after reset: `in_ready`=0 while `rst`=1 and 1 after; `alu_en`=1, `alu_op`=0, `alu_imm`=0, `op_hold`=0, `wb_valid`=0, `wb_dst`=0, `wb_vec`=0, `err`=0.
  - Reset mid-operation discards in-flight entries with no writeback.
- Latency: instruction accepted at edge t gives `wb_valid`=1 in the cycle after edge t+1, i.e. two edges later with no stall.
- Throughput: one independent instruction per cycle.
- Dependent back-to-back pair:
  - With `wb_ready`=1, the consumer issues in the cycle after the producer's wb handshake (a 2-bubble gap).
  - With a wb stall, the consumer stays blocked until the producer retires.
- Writeback stall: while `wb_valid && !wb_ready`, `alu_en`=0 and `in_ready`=0. S1, S2, `alu_imm` and the ALU outputs hold stable, and `wb_*` must not change.
- Simultaneous retire and issue in one cycle is allowed when the new instruction is hazard-free.
- `err` for a dropped op is independent of any stall on the pipeline.

## Test plan
- Independent stream: Vadd dst 1, Vsub dst 2, Fadd dst 3 on consecutive cycles, `wb_ready`=1 → `wb_valid` high for 3 consecutive cycles starting 2 cycles after the first accept; `wb_dst`=1, 2, 3; `wb_vec`=1, 1, 0; `issued_cnt`=3.
- RAW hazard: Vmult dst v4, then Vadd with vsrc1=v4 → Vadd `in_ready` low for 2 cycles, then accepted the cycle after the v4 retire.
- Backpressure: `wb_ready`=0 for 5 cycles with S2 valid (Vswizzle, imm 0x1B) → `alu_en`=0, `in_ready`=0, `alu_imm`=0x1B and `wb_dst` held throughout; resumes with no loss or duplication.
- Serialization: Vcompsel issued behind an in-flight Fmult → blocked until the pipe is empty; `op_hold`=1 for 2 cycles; the next op issues after Vcompsel retires.
- Illegal: `in_op`=15, then `in_op`=20 → both accepted, `err` pulses twice, `err_cnt`=2, no `wb_valid`.
- Reset with 2 valid entries → no `wb_valid` afterwards; `in_ready`=1 the first cycle after `rst` deasserts.
